gate3_resp_checker: RTL and testbench

GATE3_RESP_CHECKER -- requirements
Module: gate3_resp_checker

---
 rtl/gate3_chk_pkg.sv | 28 ++
 rtl/gate3_settle_timer.sv | 36 +++
 rtl/gate3_resp_checker.sv | 139 +++++++++++++
 tb/tb_gate3_resp_checker.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/gate3_chk_pkg.sv
// Shared types and constants for the 3-input gate response checker.
// Holds the FSM state enum, the vector count and the stock truth tables.
package gate3_chk_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_DRIVE  = 3'd1,
      ST_SETTLE = 3'd2,
      ST_SAMPLE = 3'd3,
      ST_DONE   = 3'd4
   } state_e;

   localparam int NUM_VECTORS = 8;

   localparam logic [7:0] TT_OR3  = 8'hFE;
   localparam logic [7:0] TT_AND3 = 8'h80;
   localparam logic [7:0] TT_XOR3 = 8'h96;

   // The settle timer is loaded with one less than the settle length so that
   // the zero flag lines up with the last SETTLE cycle.
   function automatic logic [3:0] settle_load(input int unsigned cycles);
      logic [3:0] val;
      val = 4'd0;
      if (cycles > 0) val = 4'(cycles - 1);
      return val;
   endfunction

endpackage

// File: rtl/gate3_settle_timer.sv
// 4-bit load / count-down timer with a zero flag.
// Decrements stop at zero, so the count never wraps.
module gate3_settle_timer (
   input  logic       clk,
   input  logic       rst,
   input  logic       load,
   input  logic [3:0] load_val,
   input  logic       dec,
   output logic [3:0] count,
   output logic       zero
);

   logic [3:0] cnt_d;
   logic [3:0] cnt_q;

   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = load_val;
      end else if (dec && (cnt_q != 4'd0)) begin
         cnt_d = cnt_q - 4'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= 4'd0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign count = cnt_q;
   assign zero  = (cnt_q == 4'd0);

endmodule

// File: rtl/gate3_resp_checker.sv
// Drives all eight {c,b,a} vectors into a 3-input gate, waits for it to
// settle, and compares the response y with a truth table.
module gate3_resp_checker
   import gate3_chk_pkg::*;
#(
   parameter int unsigned SETTLE_CYCLES = 2,
   parameter logic [7:0]  TRUTH_TABLE   = 8'hFE
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   output logic       a,
   output logic       b,
   output logic       c,
   input  logic       y,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [3:0] err_count,
   output logic       first_fail_valid,
   output logic [2:0] first_fail_idx,
   output state_e     dbg_state
);

   localparam logic [3:0] SETTLE_LOAD = settle_load(SETTLE_CYCLES);
   localparam logic [3:0] ERR_MAX     = 4'(NUM_VECTORS);

   state_e     state_d, state_q;
   logic [2:0] idx_d, idx_q;
   logic [2:0] abc_d, abc_q;
   logic [3:0] err_d, err_q;
   logic       ffv_d, ffv_q;
   logic [2:0] ffi_d, ffi_q;

   logic       tmr_load;
   logic       tmr_dec;
   logic       tmr_zero;
   logic [3:0] tmr_count;
   logic       mismatch;

   gate3_settle_timer u_settle_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (tmr_load),
      .load_val (SETTLE_LOAD),
      .dec      (tmr_dec),
      .count    (tmr_count),
      .zero     (tmr_zero)
   );

   assign mismatch = (y != TRUTH_TABLE[idx_q]);

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      abc_d    = abc_q;
      err_d    = err_q;
      ffv_d    = ffv_q;
      ffi_d    = ffi_q;
      tmr_load = 1'b0;
      tmr_dec  = 1'b0;

      unique case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               state_d = ST_DRIVE;
               idx_d   = 3'd0;
               abc_d   = 3'd0;
               err_d   = 4'd0;
               ffv_d   = 1'b0;
               ffi_d   = 3'd0;
            end
         end
         ST_DRIVE: begin
            tmr_load = 1'b1;
            state_d  = (SETTLE_CYCLES > 0) ? ST_SETTLE : ST_SAMPLE;
         end
         ST_SETTLE: begin
            if (tmr_zero) begin
               state_d = ST_SAMPLE;
            end else begin
               tmr_dec = 1'b1;
            end
         end
         ST_SAMPLE: begin
            if (mismatch) begin
               if (err_q < ERR_MAX) err_d = err_q + 4'd1;
               if (!ffv_q) begin
                  ffv_d = 1'b1;
                  ffi_d = idx_q;
               end
            end
            // The stimulus for the next vector is registered on the way into
            // DRIVE so a/b/c are already valid during the DRIVE cycle.
            if (idx_q == 3'd7) begin
               state_d = ST_DONE;
            end else begin
               idx_d   = idx_q + 3'd1;
               abc_d   = idx_q + 3'd1;
               state_d = ST_DRIVE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         idx_q   <= 3'd0;
         abc_q   <= 3'd0;
         err_q   <= 4'd0;
         ffv_q   <= 1'b0;
         ffi_q   <= 3'd0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         abc_q   <= abc_d;
         err_q   <= err_d;
         ffv_q   <= ffv_d;
         ffi_q   <= ffi_d;
      end
   end

   assign a                = abc_q[0];
   assign b                = abc_q[1];
   assign c                = abc_q[2];
   assign busy             = (state_q == ST_DRIVE) || (state_q == ST_SETTLE) ||
                             (state_q == ST_SAMPLE);
   assign done             = (state_q == ST_DONE);
   assign pass             = (state_q == ST_DONE) && (err_q == 4'd0);
   assign err_count        = err_q;
   assign first_fail_valid = ffv_q;
   assign first_fail_idx   = ffi_q;
   assign dbg_state        = state_q;

endmodule

// File: tb/tb_gate3_resp_checker.sv
// Directed bench for gate3_resp_checker: three instances cover the default
// settle length, zero settle, and an XOR table against an OR3 gate.
`timescale 1ns/1ps
module tb_gate3_resp_checker;
   import gate3_chk_pkg::*;

   logic clk;
   logic rst;
   logic start_def, start_s0, start_xor;
   logic y_zero;

   logic a_def, b_def, c_def, y_def, busy_def, done_def, pass_def, ffv_def;
   logic [3:0] err_def;
   logic [2:0] ffi_def;
   state_e st_def;

   logic a_s0, b_s0, c_s0, y_s0, busy_s0, done_s0, pass_s0, ffv_s0;
   logic [3:0] err_s0;
   logic [2:0] ffi_s0;
   state_e st_s0;

   logic a_x, b_x, c_x, y_x, busy_x, done_x, pass_x, ffv_x;
   logic [3:0] err_x;
   logic [2:0] ffi_x;
   state_e st_x;

   int n_checks;
   int n_pass;

   // Gate models: an OR3, optionally stuck at 0 for the default instance.
   assign y_def = y_zero ? 1'b0 : (a_def | b_def | c_def);
   assign y_s0  = a_s0 | b_s0 | c_s0;
   assign y_x   = a_x | b_x | c_x;

   gate3_resp_checker u_def (
      .clk(clk), .rst(rst), .start(start_def), .a(a_def), .b(b_def), .c(c_def),
      .y(y_def), .busy(busy_def), .done(done_def), .pass(pass_def),
      .err_count(err_def), .first_fail_valid(ffv_def), .first_fail_idx(ffi_def),
      .dbg_state(st_def)
   );

   gate3_resp_checker #(.SETTLE_CYCLES(0)) u_s0 (
      .clk(clk), .rst(rst), .start(start_s0), .a(a_s0), .b(b_s0), .c(c_s0),
      .y(y_s0), .busy(busy_s0), .done(done_s0), .pass(pass_s0),
      .err_count(err_s0), .first_fail_valid(ffv_s0), .first_fail_idx(ffi_s0),
      .dbg_state(st_s0)
   );

   gate3_resp_checker #(.TRUTH_TABLE(TT_XOR3)) u_xor (
      .clk(clk), .rst(rst), .start(start_xor), .a(a_x), .b(b_x), .c(c_x),
      .y(y_x), .busy(busy_x), .done(done_x), .pass(pass_x),
      .err_count(err_x), .first_fail_valid(ffv_x), .first_fail_idx(ffi_x),
      .dbg_state(st_x)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic check_def_zero(input string tag);
      check({tag, " abc"}, {29'd0, c_def, b_def, a_def}, 32'd0);
      check({tag, " busy"}, busy_def, 0);
      check({tag, " done"}, done_def, 0);
      check({tag, " pass"}, pass_def, 0);
      check({tag, " err"}, err_def, 0);
      check({tag, " ffv"}, ffv_def, 0);
      check({tag, " ffi"}, ffi_def, 0);
      check({tag, " state"}, st_def, ST_IDLE);
   endtask

   function automatic int min7(input int v);
      return (v > 7) ? 7 : v;
   endfunction

   initial begin
      n_checks  = 0;
      n_pass    = 0;
      rst       = 1'b1;
      start_def = 1'b0;
      start_s0  = 1'b0;
      start_xor = 1'b0;
      y_zero    = 1'b0;
      step();
      step();
      check_def_zero("reset");
      check("reset s0 done", done_s0, 0);
      rst = 1'b0;
      step();
      check_def_zero("idle");

      // Run 1: all three instances, extra start pulses on the default one.
      start_def = 1'b1;
      start_s0  = 1'b1;
      start_xor = 1'b1;
      step();
      start_s0  = 1'b0;
      start_xor = 1'b0;
      for (int m = 0; m <= 33; m++) begin
         check($sformatf("def vec m%0d", m), {29'd0, c_def, b_def, a_def}, min7(m / 4));
         check($sformatf("def done m%0d", m), done_def, (m >= 32));
         check($sformatf("def busy m%0d", m), busy_def, (m < 32));
         check($sformatf("def pass m%0d", m), pass_def, (m >= 32));
         check($sformatf("s0 vec m%0d", m), {29'd0, c_s0, b_s0, a_s0}, min7(m / 2));
         check($sformatf("s0 done m%0d", m), done_s0, (m >= 16));
         check($sformatf("s0 pass m%0d", m), pass_s0, (m >= 16));
         check($sformatf("xor err m%0d", m), err_x,
               int'(m >= 16) + int'(m >= 24) + int'(m >= 28));
         check($sformatf("xor ffv m%0d", m), ffv_x, (m >= 16));
         check($sformatf("xor ffi m%0d", m), ffi_x, (m >= 16) ? 3 : 0);
         check($sformatf("xor done m%0d", m), done_x, (m >= 32));
         start_def = (m == 4) || (m == 19);
         step();
      end
      start_def = 1'b0;
      check("def err run1", err_def, 0);
      check("def ffv run1", ffv_def, 0);
      check("xor pass run1", pass_x, 0);

      // Run 2: gate stuck at 0 against the OR3 table.
      y_zero    = 1'b1;
      start_def = 1'b1;
      step();
      start_def = 1'b0;
      for (int m = 0; m <= 32; m++) begin
         if (m == 7) begin
            check("stuck ffv m7", ffv_def, 0);
            check("stuck err m7", err_def, 0);
         end
         if (m == 8) begin
            check("stuck ffv m8", ffv_def, 1);
            check("stuck ffi m8", ffi_def, 1);
            check("stuck err m8", err_def, 1);
         end
         if (m == 32) begin
            check("stuck done", done_def, 1);
            check("stuck err", err_def, 7);
            check("stuck ffi", ffi_def, 1);
            check("stuck ffv", ffv_def, 1);
            check("stuck pass", pass_def, 0);
            check("stuck abc hold", {29'd0, c_def, b_def, a_def}, 7);
         end
         if (m < 32) step();
      end
      y_zero = 1'b0;

      // Run 3: reset mid-run, reset beating start, then a clean run.
      start_def = 1'b1;
      step();
      start_def = 1'b0;
      for (int m = 0; m < 12; m++) step();
      check("pre-rst busy", busy_def, 1);
      rst = 1'b1;
      step();
      check_def_zero("midrst");
      start_def = 1'b1;
      step();
      check_def_zero("rst prio");
      rst       = 1'b0;
      start_def = 1'b0;
      step();
      check_def_zero("after rst");
      start_def = 1'b1;
      step();
      start_def = 1'b0;
      for (int m = 0; m <= 32; m++) begin
         if (m < 32) check($sformatf("clean done m%0d", m), done_def, 0);
         if (m == 32) begin
            check("clean done", done_def, 1);
            check("clean pass", pass_def, 1);
            check("clean err", err_def, 0);
         end
         if (m < 32) step();
      end

      // Run 4: start held high gives back-to-back runs.
      start_def = 1'b1;
      step();
      for (int m = 0; m <= 66; m++) begin
         if (m == 31 || m == 32 || m == 33 || m == 64 || m == 65 || m == 66) begin
            check($sformatf("held done m%0d", m), done_def, (m == 32) || (m == 65));
            check($sformatf("held busy m%0d", m), busy_def, (m != 32) && (m != 65));
         end
         if (m == 32 || m == 65) check($sformatf("held pass m%0d", m), pass_def, 1);
         if (m == 33) check("held abc restart", {29'd0, c_def, b_def, a_def}, 0);
         step();
      end
      start_def = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
